// File: rtl/decode_pkg.sv
// Shared definitions for the decode pipeline stage: opcodes, immediate formats,
// ALU control codes and the ID/EX control record.
package decode_pkg;

    // RV32I/RV64I base opcodes handled by decode
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;

    // Immediate formats; ImmNone yields zero for formats without an immediate
    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_src_e;

    // Write-back result selection
    localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;

    // ALU control codes
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_LUI  = 5'd10;

    // Control half of the ID/EX register; all-zero is a bubble
    typedef struct packed {
        logic       valid;
        logic       uipc_add;
        logic       jump_r;
        logic       jump;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] result_src;
        logic [4:0] alu_ctrl;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '0;

    // Assemble a 32-bit sign-extended immediate from instr[31:7]
    function automatic logic [31:0] imm_ext32(input logic [31:7] ins, input imm_src_e src);
        logic [31:0] imm;
        case (src)
            ImmI:    imm = {{20{ins[31]}}, ins[31:20]};
            ImmS:    imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ImmB:    imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            ImmU:    imm = {ins[31:12], 12'b0};
            ImmJ:    imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // funct3/funct7 to ALU control; SUB only exists for register-register ops
    function automatic logic [4:0] alu_decode(input logic [2:0] f3, input logic f7_5,
                                              input logic is_op);
        logic [4:0] ctrl;
        case (f3)
            3'b000:  ctrl = (is_op && f7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  ctrl = ALU_SLL;
            3'b010:  ctrl = ALU_SLT;
            3'b011:  ctrl = ALU_SLTU;
            3'b100:  ctrl = ALU_XOR;
            3'b101:  ctrl = f7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  ctrl = ALU_OR;
            default: ctrl = ALU_AND;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/decode_pipe_stage_regfile_bypass.sv
// Register file with two read ports, one write port and write-through bypass.
// x0 and indices at or above NREGS read as zero; writes to them are dropped.
module regfile_bypass #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned RW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  logic [RW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic            wr_en;

    assign wr_en = we_i && (waddr_i != '0) && (32'(waddr_i) < NREGS);

    // Storage: cleared on reset, written on the rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: '0};
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports: a same-cycle write to the same register is forwarded
    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if ((raddr1_i != 5'd0) && (32'(raddr1_i) < NREGS)) begin
            if (wr_en && (5'(waddr_i) == raddr1_i)) rdata1_o = wdata_i;
            else                                    rdata1_o = mem_q[raddr1_i[RW-1:0]];
        end
        if ((raddr2_i != 5'd0) && (32'(raddr2_i) < NREGS)) begin
            if (wr_en && (5'(waddr_i) == raddr2_i)) rdata2_o = wdata_i;
            else                                    rdata2_o = mem_q[raddr2_i[RW-1:0]];
        end
    end

endmodule

// File: rtl/decode_pipe_stage.sv
// Decode stage: instruction decode, register read with write-back bypass,
// load-use hazard detection and an owned ID/EX register (stall/bubble/flush).
// Optional macro DECODE_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module decode_pipe_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned RW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
`ifdef DECODE_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    input  logic             valid_d,
    input  logic [31:0]      instr_d,
    input  logic [XLEN-1:0]  pc_now_d,
    input  logic [XLEN-1:0]  pc_plus4_d,
    input  logic             reg_write_w,
    input  logic [RW-1:0]    rd_w,
    input  logic [XLEN-1:0]  result_w,
    input  logic             hold_e,
    input  logic             flush_e,
    output logic             stall_d,
    output logic             valid_e,
    output logic             uipc_add_e,
    output logic             jump_r_e,
    output logic             jump_e,
    output logic             branch_e,
    output logic             reg_write_e,
    output logic             mem_write_e,
    output logic             alu_src_e,
    output logic [1:0]       result_src_e,
    output logic [4:0]       alu_ctrl_e,
    output logic [XLEN-1:0]  read_data1_e,
    output logic [XLEN-1:0]  read_data2_e,
    output logic [XLEN-1:0]  imm_ext_e,
    output logic [XLEN-1:0]  pc_now_e,
    output logic [XLEN-1:0]  pc_plus4_e,
    output logic [RW-1:0]    rs1_e,
    output logic [RW-1:0]    rs2_e,
    output logic [RW-1:0]    rd_e
);

    logic [6:0]      opcode;
    logic [RW-1:0]   rs1_idx, rs2_idx, rd_idx;
    idex_t           ctrl_dec;
    imm_src_e        imm_src;
    logic [XLEN-1:0] imm_dec, rdata1, rdata2;
    logic            hz, bubble, capture;

    idex_t           ctrl_q, ctrl_d;
    logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d, pc4_q, pc4_d;
    logic [RW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;

    assign opcode  = instr_d[6:0];
    assign rs1_idx = instr_d[15 +: RW];
    assign rs2_idx = instr_d[20 +: RW];
    assign rd_idx  = instr_d[7 +: RW];

    regfile_bypass #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .raddr1_i (instr_d[19:15]),
        .raddr2_i (instr_d[24:20]),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2),
        .we_i     (reg_write_w),
        .waddr_i  (rd_w),
        .wdata_i  (result_w)
    );

    // Control decode from opcode/funct fields
    always_comb begin
        ctrl_dec       = IDEX_BUBBLE;
        ctrl_dec.valid = valid_d;
        imm_src        = ImmNone;
        case (opcode)
            OP_LOAD: begin
                ctrl_dec.reg_write  = 1'b1;
                ctrl_dec.alu_src    = 1'b1;
                ctrl_dec.result_src = RESULT_SRC_LOAD;
                imm_src             = ImmI;
            end
            OP_STORE: begin
                ctrl_dec.mem_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                imm_src            = ImmS;
            end
            OP_BRANCH: begin
                ctrl_dec.branch   = 1'b1;
                ctrl_dec.alu_ctrl = ALU_SUB;
                imm_src           = ImmB;
            end
            OP_JAL: begin
                ctrl_dec.jump       = 1'b1;
                ctrl_dec.reg_write  = 1'b1;
                ctrl_dec.result_src = RESULT_SRC_PC4;
                imm_src             = ImmJ;
            end
            OP_JALR: begin
                ctrl_dec.jump_r     = 1'b1;
                ctrl_dec.reg_write  = 1'b1;
                ctrl_dec.alu_src    = 1'b1;
                ctrl_dec.result_src = RESULT_SRC_PC4;
                imm_src             = ImmI;
            end
            OP_LUI: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.alu_ctrl  = ALU_LUI;
                imm_src            = ImmU;
            end
            OP_AUIPC: begin
                ctrl_dec.uipc_add  = 1'b1;
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                imm_src            = ImmU;
            end
            OP_OP: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_ctrl  = alu_decode(instr_d[14:12], instr_d[30], 1'b1);
            end
            OP_OPIMM: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.alu_ctrl  = alu_decode(instr_d[14:12], instr_d[30], 1'b0);
                imm_src            = ImmI;
            end
            default: ;
        endcase
    end

    assign imm_dec = XLEN'($signed(imm_ext32(instr_d[31:7], imm_src)));

    // Load-use hazard and stall/bubble priority: flush > hold > hazard > capture
    always_comb begin
        // rs2 is compared even when the format has no rs2 (conservative)
        hz = ctrl_q.valid && ctrl_q.reg_write && (ctrl_q.result_src == RESULT_SRC_LOAD) &&
             (rd_q != '0) && ((rd_q == rs1_idx) || (rd_q == rs2_idx)) && valid_d;
        stall_d = reset && !flush_e && (hold_e || hz);
        bubble  = flush_e || (!hold_e && (hz || !valid_d));
        capture = !flush_e && !hold_e && !hz && valid_d;
    end

    // ID/EX next state: bubble, capture or hold
    always_comb begin
        ctrl_d = ctrl_q;
        rd1_d  = rd1_q;
        rd2_d  = rd2_q;
        imm_d  = imm_q;
        pc_d   = pc_q;
        pc4_d  = pc4_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        rd_d   = rd_q;
        if (bubble) begin
            ctrl_d = IDEX_BUBBLE;
            rd1_d  = '0;
            rd2_d  = '0;
            imm_d  = '0;
            pc_d   = '0;
            pc4_d  = '0;
            rs1_d  = '0;
            rs2_d  = '0;
            rd_d   = '0;
        end else if (capture) begin
            ctrl_d = ctrl_dec;
            rd1_d  = rdata1;
            rd2_d  = rdata2;
            imm_d  = imm_dec;
            pc_d   = pc_now_d;
            pc4_d  = pc_plus4_d;
            rs1_d  = rs1_idx;
            rs2_d  = rs2_idx;
            rd_d   = rd_idx;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= IDEX_BUBBLE;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            pc_q   <= '0;
            pc4_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            pc_q   <= pc_d;
            pc4_q  <= pc4_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            rd_q   <= rd_d;
        end
    end

    assign valid_e      = ctrl_q.valid;
    assign uipc_add_e   = ctrl_q.uipc_add;
    assign jump_r_e     = ctrl_q.jump_r;
    assign jump_e       = ctrl_q.jump;
    assign branch_e     = ctrl_q.branch;
    assign reg_write_e  = ctrl_q.reg_write;
    assign mem_write_e  = ctrl_q.mem_write;
    assign alu_src_e    = ctrl_q.alu_src;
    assign result_src_e = ctrl_q.result_src;
    assign alu_ctrl_e   = ctrl_q.alu_ctrl;
    assign read_data1_e = rd1_q;
    assign read_data2_e = rd2_q;
    assign imm_ext_e    = imm_q;
    assign pc_now_e     = pc_q;
    assign pc_plus4_e   = pc4_q;
    assign rs1_e        = rs1_q;
    assign rs2_e        = rs2_q;
    assign rd_e         = rd_q;

`ifdef DECODE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hz && !flush_e && !hold_e && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_e && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Self-checking bench for decode_pipe_stage: directed scenarios followed by
// randomized instruction streams, compared against a behavioural model.
module tb_decode_pipe_stage;
    import decode_pkg::*;

    localparam int unsigned TB_CNT_W = 2;

    localparam int K_LW = 0, K_SW = 1, K_BEQ = 2, K_JAL = 3, K_JALR = 4;
    localparam int K_LUI = 5, K_AUIPC = 6, K_ADD = 7, K_SUB = 8, K_ADDI = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_d;
    logic [31:0] instr_d, pc_now_d, pc_plus4_d, result_w;
    logic        reg_write_w, hold_e, flush_e;
    logic [4:0]  rd_w;
    logic        stall_d, valid_e, uipc_add_e, jump_r_e, jump_e, branch_e;
    logic        reg_write_e, mem_write_e, alu_src_e;
    logic [1:0]  result_src_e;
    logic [4:0]  alu_ctrl_e;
    logic [31:0] read_data1_e, read_data2_e, imm_ext_e, pc_now_e, pc_plus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
`ifdef DECODE_PERF_CNT_EN
    logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    decode_pipe_stage #(
        .XLEN  (32),
        .NREGS (32),
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef DECODE_PERF_CNT_EN
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .valid_d      (valid_d),
        .instr_d      (instr_d),
        .pc_now_d     (pc_now_d),
        .pc_plus4_d   (pc_plus4_d),
        .reg_write_w  (reg_write_w),
        .rd_w         (rd_w),
        .result_w     (result_w),
        .hold_e       (hold_e),
        .flush_e      (flush_e),
        .stall_d      (stall_d),
        .valid_e      (valid_e),
        .uipc_add_e   (uipc_add_e),
        .jump_r_e     (jump_r_e),
        .jump_e       (jump_e),
        .branch_e     (branch_e),
        .reg_write_e  (reg_write_e),
        .mem_write_e  (mem_write_e),
        .alu_src_e    (alu_src_e),
        .result_src_e (result_src_e),
        .alu_ctrl_e   (alu_ctrl_e),
        .read_data1_e (read_data1_e),
        .read_data2_e (read_data2_e),
        .imm_ext_e    (imm_ext_e),
        .pc_now_e     (pc_now_e),
        .pc_plus4_e   (pc_plus4_e),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .rd_e         (rd_e)
    );

    typedef struct {
        int          kind;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] pc;
    } inst_t;

    typedef struct {
        logic        valid, uipc, jr, j, br, rw, mw, asrc;
        logic [1:0]  rsrc;
        logic [4:0]  alu;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } exp_t;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] rf [32];
    exp_t        ex;
    logic        last_exp_stall, obs_stall;
    int          m_stall_cnt, m_flush_cnt;
    int unsigned cnt_max = (1 << TB_CNT_W) - 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t bubble();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    // Encode an instruction of the given kind carrying the given immediate
    function automatic inst_t mk(int kind, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                 logic [31:0] imm);
        inst_t t;
        t.kind = kind;
        t.imm  = imm;
        t.pc   = $urandom & 32'hFFFF_FFFC;
        case (kind)
            K_LW:    t.instr = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
            K_SW:    t.instr = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
            K_BEQ:   t.instr = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BRANCH};
            K_JAL:   t.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            K_JALR:  t.instr = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            K_LUI:   t.instr = {imm[31:12], rd, OP_LUI};
            K_AUIPC: t.instr = {imm[31:12], rd, OP_AUIPC};
            K_ADD:   t.instr = {7'b0000000, rs2, rs1, 3'b000, rd, OP_OP};
            K_SUB:   t.instr = {7'b0100000, rs2, rs1, 3'b000, rd, OP_OP};
            default: t.instr = {imm[11:0], rs1, 3'b000, rd, OP_OPIMM};
        endcase
        return t;
    endfunction

    function automatic inst_t gen();
        int          kind;
        logic [31:0] r, imm;
        logic [4:0]  rd, rs1, rs2;
        kind = $urandom_range(0, 9);
        r    = $urandom;
        rd   = 5'($urandom_range(0, 7));
        rs1  = 5'($urandom_range(0, 7));
        rs2  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        case (kind)
            K_BEQ:          imm = {{19{r[12]}}, r[12:1], 1'b0};
            K_JAL:          imm = {{11{r[20]}}, r[20:1], 1'b0};
            K_LUI, K_AUIPC: imm = {r[31:12], 12'b0};
            K_ADD, K_SUB:   imm = 32'd0;
            default:        imm = {{20{r[11]}}, r[11:0]};
        endcase
        return mk(kind, rd, rs1, rs2, imm);
    endfunction

    function automatic logic [31:0] rf_read(logic [4:0] idx, logic wen, logic [4:0] wrd,
                                            logic [31:0] wres);
        if (idx == 5'd0) return 32'd0;
        if (wen && wrd == idx) return wres;
        return rf[idx];
    endfunction

    // What the ID/EX register should hold after capturing instruction t
    function automatic exp_t expect_of(inst_t t, logic [31:0] rd1, logic [31:0] rd2);
        exp_t e;
        e       = bubble();
        e.valid = 1'b1;
        e.alu   = ALU_ADD;
        case (t.kind)
            K_LW:    begin e.rw = 1; e.asrc = 1; e.rsrc = RESULT_SRC_LOAD; end
            K_SW:    begin e.mw = 1; e.asrc = 1; end
            K_BEQ:   begin e.br = 1; e.alu = ALU_SUB; end
            K_JAL:   begin e.j = 1; e.rw = 1; e.rsrc = RESULT_SRC_PC4; end
            K_JALR:  begin e.jr = 1; e.rw = 1; e.asrc = 1; e.rsrc = RESULT_SRC_PC4; end
            K_LUI:   begin e.rw = 1; e.asrc = 1; e.alu = ALU_LUI; end
            K_AUIPC: begin e.uipc = 1; e.rw = 1; e.asrc = 1; end
            K_ADD:   e.rw = 1;
            K_SUB:   begin e.rw = 1; e.alu = ALU_SUB; end
            default: begin e.rw = 1; e.asrc = 1; end
        endcase
        e.imm = t.imm;
        e.rd1 = rd1;
        e.rd2 = rd2;
        e.pc  = t.pc;
        e.pc4 = t.pc + 32'd4;
        e.rs1 = t.instr[19:15];
        e.rs2 = t.instr[24:20];
        e.rd  = t.instr[11:7];
        return e;
    endfunction

    task automatic check_outputs(input string pfx);
        check({pfx, "ctrl"}, {valid_e, uipc_add_e, jump_r_e, jump_e, branch_e, reg_write_e,
                              mem_write_e, alu_src_e, result_src_e, alu_ctrl_e},
              {ex.valid, ex.uipc, ex.jr, ex.j, ex.br, ex.rw, ex.mw, ex.asrc, ex.rsrc, ex.alu});
        check({pfx, "rd1"}, read_data1_e, ex.rd1);
        check({pfx, "rd2"}, read_data2_e, ex.rd2);
        check({pfx, "imm"}, imm_ext_e, ex.imm);
        check({pfx, "pc"}, pc_now_e, ex.pc);
        check({pfx, "pc4"}, pc_plus4_e, ex.pc4);
        check({pfx, "idx"}, {rs1_e, rs2_e, rd_e}, {ex.rs1, ex.rs2, ex.rd});
`ifdef DECODE_PERF_CNT_EN
        check({pfx, "stall_cnt"}, stall_cnt, m_stall_cnt);
        check({pfx, "flush_cnt"}, flush_cnt, m_flush_cnt);
`endif
    endtask

    task automatic model_reset();
        ex = bubble();
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    // One clock: drive at posedge+1, check stall_d, then check ID/EX after the edge
    task automatic cycle(input inst_t t, input logic vd, input logic hold, input logic flush,
                         input logic wen, input logic [4:0] wrd, input logic [31:0] wres);
        exp_t nx;
        logic hz, es;
        instr_d     = t.instr;
        valid_d     = vd;
        pc_now_d    = t.pc;
        pc_plus4_d  = t.pc + 32'd4;
        hold_e      = hold;
        flush_e     = flush;
        reg_write_w = wen;
        rd_w        = wrd;
        result_w    = wres;
        #1;
        hz = ex.valid && ex.rw && (ex.rsrc == 2'b01) && (ex.rd != 5'd0) &&
             ((ex.rd == t.instr[19:15]) || (ex.rd == t.instr[24:20])) && vd;
        es = !flush && (hold || hz);
        obs_stall = stall_d;
        check("stall_d", stall_d, es);
        last_exp_stall = es;
        if (flush || (!hold && (hz || !vd))) nx = bubble();
        else if (hold) nx = ex;
        else nx = expect_of(t, rf_read(t.instr[19:15], wen, wrd, wres),
                            rf_read(t.instr[24:20], wen, wrd, wres));
        if (hz && !flush && !hold && m_stall_cnt < int'(cnt_max)) m_stall_cnt++;
        if (flush && m_flush_cnt < int'(cnt_max)) m_flush_cnt++;
        @(posedge clk);
        if (wen && wrd != 5'd0) rf[wrd] = wres;
        ex = nx;
        #1;
        check_outputs("");
    endtask

    task automatic idle_inputs();
        valid_d     = 1'b0;
        hold_e      = 1'b0;
        flush_e     = 1'b0;
        reg_write_w = 1'b0;
        rd_w        = 5'd0;
        result_w    = 32'd0;
    endtask

    initial begin
        inst_t       cur, tmp;
        logic        cur_v;
        logic [4:0]  wrd;

        // Reset with a live instruction presented
        reset = 1'b0;
        idle_inputs();
        valid_d    = 1'b1;
        instr_d    = $urandom;
        pc_now_d   = $urandom;
        pc_plus4_d = $urandom;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall_d, 1'b0);
        check_outputs("rst_");
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Preload x1=5, x2=7 then capture add x3,x1,x2
        cycle(mk(K_ADD, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5);
        cycle(mk(K_ADD, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd7);
        cycle(mk(K_ADD, 3, 1, 2, 0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("cap_rd1", read_data1_e, 32'd5);
        check("cap_rd2", read_data2_e, 32'd7);
        check("cap_rd", {valid_e, reg_write_e, rd_e}, {1'b1, 1'b1, 5'd3});

        // Load-use: lw x5,0(x1) then add x6,x5,x1
        cycle(mk(K_LW, 5, 1, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        tmp = mk(K_ADD, 6, 5, 1, 0);
        cycle(tmp, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("lu_stall", obs_stall, 1'b1);
        check("lu_bubble", valid_e, 1'b0);
        cycle(tmp, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("lu_rs1", {valid_e, rs1_e}, {1'b1, 5'd5});

        // Bypass from write-back, x0 stays zero
        cycle(mk(K_ADD, 8, 7, 0, 0), 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        check("byp_rd1", read_data1_e, 32'hDEAD_BEEF);
        check("byp_rd2", read_data2_e, 32'd0);
        cycle(mk(K_ADD, 9, 0, 7, 0), 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234_5678);
        check("x0_byp", read_data1_e, 32'd0);
        cycle(mk(K_ADD, 9, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("x0_rd", read_data1_e, 32'd0);

        // Flush + hold + hazard together
        cycle(mk(K_LW, 5, 1, 0, 4), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(mk(K_ADD, 6, 5, 5, 0), 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        check("fhz_stall", obs_stall, 1'b0);
        check("fhz_bubble", valid_e, 1'b0);

        // Hold alone for three cycles freezes addi x4
        cycle(mk(K_ADDI, 4, 1, 0, 32'hFFFF_FFF0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(gen(), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
            check("hold_stall", obs_stall, 1'b1);
            check("hold_rd", {valid_e, rd_e, imm_ext_e}, {1'b1, 5'd4, 32'hFFFF_FFF0});
        end

        // Reset asserted while a load-use stall is active
        cycle(mk(K_LW, 5, 1, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        idle_inputs();
        tmp        = mk(K_ADD, 6, 5, 1, 0);
        instr_d    = tmp.instr;
        valid_d    = 1'b1;
        #2;
        check("mid_stall_pre", stall_d, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_stall_drop", stall_d, 1'b0);
        check("mid_valid", valid_e, 1'b0);
        model_reset();
        valid_d = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst_");

        // Randomized stream; the instruction is re-presented while stalled
        cur   = gen();
        cur_v = 1'b1;
        for (int i = 0; i < 500; i++) begin
            wrd = 5'($urandom_range(0, 7));
            cycle(cur, cur_v, ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 1) == 1), wrd, $urandom);
            if (!last_exp_stall) begin
                cur   = gen();
                cur_v = ($urandom_range(0, 7) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode_pipe_stage.md
Name: decode_pipe_stage

Overview:
Parametrised successor to the single-cycle decode block for the pipelined RISC-V core. It decodes the IF/ID instruction, reads a register file with write-back bypass, and detects load-use hazards. Results are captured into an owned ID/EX pipeline register that supports stall, bubble and flush. It sits between the IF/ID register and the execute stage.

Parameters:
XLEN, 32, datapath/PC width (32 or 64)
NREGS, 32, architectural register count (16 for RV32E, 32 otherwise); index width RW = $clog2(NREGS)
CNT_W, 16, perf counter width (used only with the optional feature)

Ports:
clk  in  1  rising-edge clock
reset  in  1  one clock; reset is asynchronous and active-low
valid_d  in  1  IF/ID holds a real instruction
instr_d  in  32  instruction in decode
pc_now_d  in  XLEN  PC of instr_d
pc_plus4_d  in  XLEN  PC+4 of instr_d
reg_write_w  in  1  write-back enable
rd_w  in  RW  write-back destination
result_w  in  XLEN  write-back data
hold_e  in  1  execute cannot accept; freeze ID/EX
flush_e  in  1  branch/jump resolved taken; kill decode contents
stall_d  out  1  freeze PC and IF/ID this cycle
valid_e, uipc_add_e, jump_r_e, jump_e, branch_e, reg_write_e, mem_write_e, alu_src_e  out  1 each  registered controls
result_src_e  out  2  registered; 2'b01 = load
alu_ctrl_e  out  5  registered
read_data1_e, read_data2_e, imm_ext_e, pc_now_e, pc_plus4_e  out  XLEN each  registered
rs1_e, rs2_e, rd_e  out  RW each  registered indices for forwarding

Behaviour:
- Reset (async, low): all ID/EX outputs 0. Register file cleared to 0. Counters cleared.
- Latency: one cycle from decode to the ID/EX outputs.
- Decode: combinational opcode/funct decode. Immediate from instr_d[31:7] per ImmSrc (I/S/B/U/J), sign-extended to XLEN.
- Register file: x0 always reads 0. Write at posedge when reg_write_w && rd_w != 0. Bypass: a read index equal to a nonzero rd_w with reg_write_w returns result_w in the same cycle. Indices >= NREGS read 0; writes to them are ignored.
- Load-use hazard: hz = valid_e && reg_write_e && result_src_e == 2'b01 && rd_e != 0 && (rd_e == rs1 || rd_e == rs2) && valid_d. Comparison is conservative: rs2 is compared even for formats that do not use it.
- Per-edge priority, highest first:
  1. flush_e: load a bubble; stall_d = 0. Flush overrides hold_e.
  2. hold_e: ID/EX unchanged; stall_d = 1.
  3. hz: load a bubble; stall_d = 1. The decode instruction is re-presented next cycle.
  4. Otherwise capture the decode results; valid_e = valid_d. If valid_d = 0, load a bubble.
- Bubble: valid_e, reg_write_e, mem_write_e, branch_e, jump_e, jump_r_e, uipc_add_e all 0; every other field 0.
- stall_d is combinational from the current inputs and the ID/EX state.
- Reset mid-stall: state clears immediately and stall_d drops once reset is asserted.

Optional Feature:
DECODE_PERF_CNT_EN:
- Defined: adds outputs stall_cnt and flush_cnt, CNT_W wide, saturating.
  - stall_cnt increments each cycle hz && !flush_e && !hold_e.
  - flush_cnt increments each cycle flush_e.
  - Both cleared by reset.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package decode_pkg:
  - opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_OP, OP_OPIMM)
  - ImmSrc encodings
  - RESULT_SRC_LOAD = 2'b01
  - ALU control codes
  - idex_t record for bubble/capture
- One sub-module: regfile_bypass (parametrised XLEN/NREGS, two read ports, one write port, write-through).
- Reuse the existing control unit and extender as-is.

Test Plan:
- Reset: hold reset low with a random instr_d -> all outputs 0 and stall_d = 0; release -> the first valid capture appears after one edge.
- Capture: x1=5, x2=7 preloaded; decode add x3,x1,x2 -> next edge read_data1_e=5, read_data2_e=7, reg_write_e=1, rd_e=3, valid_e=1.
- Load-use: lw x5,0(x1) in EX; add x6,x5,x1 in decode -> stall_d=1 and a bubble on the next edge; the following edge captures add with rs1_e=5.
- Bypass and x0: reg_write_w=1, rd_w=7, result_w=32'hDEADBEEF while decoding add x8,x7,x0 -> read_data1_e=32'hDEADBEEF, read_data2_e=0. A write to x0 leaves x0 reading 0.
- Flush vs hold vs hazard: assert flush_e, hold_e and hz together -> bubble loaded, stall_d=0. hold_e alone for 3 cycles -> outputs frozen, stall_d=1.
- With DECODE_PERF_CNT_EN: 4 load-use stalls and 2 flushes -> stall_cnt=4, flush_cnt=2. Saturation is checked with CNT_W=2 (count stops at 3).
